// File: rtl/codec_reg_sequencer.sv
// Expands 16-bit CODEC register accesses into I2C-master Wishbone transactions: walks the init ROM
// after reset, then serves host requests. Optional watchdog: CODEC_SEQ_WB_TIMEOUT_EN.
module codec_reg_sequencer #(
  parameter logic [6:0]  CODEC_I2C_ADDR = 7'h1A,
  parameter int unsigned NUM_INIT       = 10,
  parameter logic [2:0]  REG_STATUS     = 3'h0,
  parameter logic [2:0]  REG_CMD_ADDR   = 3'h2,
  parameter logic [2:0]  REG_CMD        = 3'h3,
  parameter logic [2:0]  REG_DATA       = 3'h4
`ifdef CODEC_SEQ_WB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic [6:0]  init_idx,
  input  logic [15:0] init_entry,
  output logic        init_done,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [8:0]  host_wdata,
  output logic [8:0]  host_rdata,
  output logic        host_done,
  output logic        busy,
  output logic        err,
  output logic [2:0]  wbs_adr_o,
  output logic [7:0]  wbs_dat_o,
  input  logic [7:0]  wbs_dat_i,
  output logic        wbs_we_o,
  output logic        wbs_stb_o,
  output logic        wbs_cyc_o,
  input  logic        wbs_ack_i
);

  localparam int unsigned STEP_W = 4;

  typedef enum logic [2:0] {
    INIT_FETCH, HOST_IDLE, OP_STEP, WB_ACC, WB_WAIT_ACK, WB_GAP, POLL, DONE
  } state_e;

  typedef enum logic [1:0] {K_WR, K_POLL, K_RD} kind_e;

  state_e            state_q;
  logic [STEP_W-1:0] step_q;
  logic              op_we_q, op_host_q, abort_q;
  logic [6:0]        op_addr_q;
  logic [8:0]        op_data_q;
  logic              hi_q;
  logic [7:0]        lo_q;
  logic [6:0]        init_idx_q;
  logic              init_done_q, busy_q, host_done_q;
  logic [8:0]        host_rdata_q;
  logic [2:0]        adr_q;
  logic [7:0]        dat_q;
  logic              we_q, stb_q, cyc_q;

  kind_e             kind_c;
  logic [2:0]        acc_adr_c;
  logic [7:0]        acc_dat_c;
  logic              last_c;

`ifdef CODEC_SEQ_WB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Wishbone access implied by the current step of the current op
  always_comb begin
    kind_c    = K_WR;
    acc_adr_c = REG_CMD;
    acc_dat_c = 8'h00;
    last_c    = op_we_q ? (step_q == 4'd5) : (step_q == 4'd8);
    if (op_we_q) begin
      case (step_q)
        4'd0:    begin acc_adr_c = REG_CMD_ADDR; acc_dat_c = {1'b0, CODEC_I2C_ADDR}; end
        4'd1:    begin acc_adr_c = REG_DATA; acc_dat_c = {op_addr_q, op_data_q[8]}; end
        4'd2:    acc_dat_c = 8'h05;
        4'd3:    begin acc_adr_c = REG_DATA; acc_dat_c = op_data_q[7:0]; end
        4'd4:    acc_dat_c = 8'h14;
        default: begin kind_c = K_POLL; acc_adr_c = REG_STATUS; end
      endcase
    end else begin
      case (step_q)
        4'd0:       begin acc_adr_c = REG_CMD_ADDR; acc_dat_c = {1'b0, CODEC_I2C_ADDR}; end
        4'd1:       begin acc_adr_c = REG_DATA; acc_dat_c = {op_addr_q, 1'b0}; end
        4'd2:       acc_dat_c = 8'h05;
        4'd3:       acc_dat_c = 8'h03;
        4'd4, 4'd7: begin kind_c = K_POLL; acc_adr_c = REG_STATUS; end
        4'd6:       acc_dat_c = 8'h12;
        default:    begin kind_c = K_RD; acc_adr_c = REG_DATA; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT_FETCH;
      step_q       <= '0;
      op_we_q      <= 1'b0;
      op_host_q    <= 1'b0;
      abort_q      <= 1'b0;
      op_addr_q    <= '0;
      op_data_q    <= '0;
      hi_q         <= 1'b0;
      lo_q         <= '0;
      init_idx_q   <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      host_done_q  <= 1'b0;
      host_rdata_q <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      stb_q        <= 1'b0;
      cyc_q        <= 1'b0;
`ifdef CODEC_SEQ_WB_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      host_done_q <= 1'b0;
      case (state_q)
        INIT_FETCH: begin
          op_addr_q <= init_entry[15:9];
          op_data_q <= init_entry[8:0];
          op_we_q   <= 1'b1;
          op_host_q <= 1'b0;
          abort_q   <= 1'b0;
          step_q    <= '0;
          state_q   <= OP_STEP;
        end
        HOST_IDLE: begin
          // the host_done cycle itself never accepts a new request
          if (host_req && !host_done_q) begin
            op_addr_q <= host_addr;
            op_data_q <= host_wdata;
            op_we_q   <= host_we;
            op_host_q <= 1'b1;
            abort_q   <= 1'b0;
            step_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= OP_STEP;
          end
        end
        OP_STEP, WB_GAP, POLL: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= (kind_c == K_WR);
          adr_q   <= acc_adr_c;
          dat_q   <= acc_dat_c;
          state_q <= WB_ACC;
`ifdef CODEC_SEQ_WB_TIMEOUT_EN
          if (state_q != POLL) tmo_q <= '0;
`endif
        end
        WB_ACC, WB_WAIT_ACK: begin
          if (wbs_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (kind_c == K_POLL && wbs_dat_i[0]) begin
              state_q <= POLL;
            end else begin
              if (kind_c == K_RD) begin
                if (step_q == 4'd5) hi_q <= wbs_dat_i[0];
                else                lo_q <= wbs_dat_i;
              end
              if (last_c) begin
                state_q <= DONE;
              end else begin
                step_q  <= step_q + 4'd1;
                state_q <= WB_GAP;
              end
            end
          end else begin
            state_q <= WB_WAIT_ACK;
          end
        end
        DONE: begin
          if (op_host_q) begin
            host_done_q <= 1'b1;
            busy_q      <= 1'b0;
            if (abort_q)       host_rdata_q <= '0;
            else if (!op_we_q) host_rdata_q <= {hi_q, lo_q};
            state_q <= HOST_IDLE;
          end else if (init_idx_q == 7'(NUM_INIT - 1)) begin
            init_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= HOST_IDLE;
          end else begin
            init_idx_q <= init_idx_q + 7'd1;
            state_q    <= INIT_FETCH;
          end
        end
      endcase
`ifdef CODEC_SEQ_WB_TIMEOUT_EN
      // watchdog spans one access, or a whole status-poll loop
      if (state_q == WB_ACC || state_q == WB_WAIT_ACK || state_q == POLL) begin
        if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
          err_q   <= 1'b1;
          abort_q <= 1'b1;
          state_q <= DONE;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
      end
`endif
    end
  end

  assign init_idx   = init_idx_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign host_done  = host_done_q;
  assign host_rdata = host_rdata_q;
  assign wbs_adr_o  = adr_q;
  assign wbs_dat_o  = dat_q;
  assign wbs_we_o   = we_q;
  assign wbs_stb_o  = stb_q;
  assign wbs_cyc_o  = cyc_q;

endmodule
